imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the tiny CPU instruction ROM: receives a framed byte stream
//  (e.g. from a UART RX), assembles little-endian 32-bit instruction words and
//  writes them into a DEPTH-word instruction RAM. Serves the CPU's fetch port
//  (rd_addr -> rd_data). Holds the CPU (cpu_hold) until a checksum-verified
//  program is resident.
// PARAMETERS
//  DEPTH      16      instruction words in RAM
//  ADDR_W     4       address width, clog2(DEPTH)
//  SYNC_BYTE  8'hA5   frame start byte
// PORTS
//  CLK           in   1         system clock, all logic on posedge
//  RST           in   1         synchronous reset, active-high
//  rx_data       in   8         incoming byte
//  rx_valid      in   1         rx_data valid; byte taken when rx_valid & rx_ready
//  rx_ready      out  1         loader can accept a byte
//  rd_addr       in   ADDR_W    CPU fetch address (PC)
//  rd_data       out  32        instruction at rd_addr, 1-cycle latency
//  cpu_hold      out  1         1 = CPU must stay stalled/in reset
//  load_done     out  1         valid program loaded
//  load_err      out  1         last frame rejected
//  words_loaded  out  ADDR_W+1  words written in current/last frame
// BEHAVIOUR
//  Frame: SYNC_BYTE, N (word count, 1..DEPTH), 4*N data bytes (LSB first),
//    CSUM = XOR of all 4*N data bytes.
//  Reset (RST=1, highest priority): state IDLE, rx_ready=1, cpu_hold=1,
//    load_done=0, load_err=0, words_loaded=0, rd_data=0. RAM not cleared.
//  rx_ready=1 in every state; no internal backpressure. Bytes arriving with
//    rx_valid=0 are ignored; gaps of any length between bytes are legal.
//  States / transitions (on accepted byte b):
//   IDLE : b==SYNC_BYTE -> COUNT; else stay.
//   COUNT: clear load_err, load_done, words_loaded, addr, byte_idx, csum.
//          b==0 or b>DEPTH -> ERROR (load_err=1); else latch N -> DATA.
//   DATA : place b in lane byte_idx of word buffer; csum^=b; byte_idx++.
//          byte_idx==3: write RAM[addr]={b,buf[23:0]} same edge; addr++,
//          words_loaded++, byte_idx=0; if words_loaded+1==N -> CHECK.
//   CHECK: b==csum -> DONE, load_done=1; else -> ERROR, load_err=1.
//   DONE : b==SYNC_BYTE -> COUNT (reload); other bytes ignored.
//   ERROR: b==SYNC_BYTE -> COUNT; other bytes ignored.
//  cpu_hold: registered, 0 only while state==DONE; asserts the cycle after
//    leaving DONE. load_done/load_err are sticky until the next COUNT entry.
//  Outputs change only on clock edges; no combinational path rx_* -> outputs.
//  Read port: rd_data <= RAM[rd_addr] every cycle. Write and read of the same
//    address in one cycle returns OLD data. Reads during a load are legal;
//    content is only guaranteed once load_done=1.
//  Address counter never wraps: N<=DEPTH guarantees addr stays in range.
//  RST mid-frame: back to IDLE, words already written stay in RAM, hold=1.
//  Write word width 32; csum 8 bits; words_loaded ADDR_W+1 bits (holds DEPTH).
// STRUCTURE
//  tiny_cpu_pkg: state enum typedef (IDLE, COUNT, DATA, CHECK, DONE, ERROR),
//    XLEN=32, default SYNC_BYTE, IMEM_DEPTH.
//  Sub-module imem_ram: DEPTH x 32 synchronous RAM, 1 write port, 1 read
//    port, read-before-write; the loader FSM drives its write port.
// TESTING
//  1 Frame A5,02,93,00,50,00,13,01,30,00,E1 -> RAM[0]=00500093,
//    RAM[1]=00300113, load_done=1, cpu_hold=0, words_loaded=2, load_err=0.
//  2 Same frame with CSUM E0 -> load_err=1, cpu_hold=1, load_done=0; then
//    send frame 1 again -> load_err=0, load_done=1.
//  3 A5,00 and A5,11 (N=17) -> ERROR right after count byte, load_err=1,
//    no RAM writes (words_loaded=0).
//  4 Garbage 00,FF,5A before frame 1, plus random rx_valid gaps -> same
//    result as scenario 1.
//  5 RST after 6 data bytes of frame 1 -> IDLE, cpu_hold=1, words_loaded=0,
//    RAM[0]=00500093 retained; fresh frame 1 then succeeds.
//  6 After load: rd_addr=1 -> rd_data=00300113 next cycle; in DONE send A5
//    -> cpu_hold=1 the following cycle, load_done=0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int          XLEN          = 32;
    localparam int          IMEM_DEPTH    = 16;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Completes a little-endian word from the three buffered low bytes
    // and the byte that is arriving now.
    function automatic logic [XLEN-1:0] merge_word(input logic [23:0] low,
                                                   input logic [7:0]  top);
        return {top, low};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and CPU fetch port of the instruction-memory loader.
import imem_loader_pkg::*;

interface imem_loader_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]   rd_data;

    modport master (
        output rx_data, rx_valid, rd_addr,
        input  rx_ready, rd_data
    );

    modport slave (
        input  rx_data, rx_valid, rd_addr,
        output rx_ready, rd_data
    );
endinterface

// File: rtl/imem_loader_ram.sv
// DEPTH x W synchronous RAM, one write and one read port. A read and a
// write to the same address on the same edge returns the old contents.
import imem_loader_pkg::*;

module imem_loader_ram #(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int W      = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [W-1:0]      wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [W-1:0]      rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read, kept in its own block so it always sees pre-write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a framed, checksummed byte stream into the instruction RAM and
// holds the CPU until a verified program is resident.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | after reset, hunting for the sync byte
//  ST_COUNT | sync seen, next byte is the word count N
//  ST_DATA  | collecting 4*N data bytes, writing each completed word
//  ST_CHECK | next byte is the XOR checksum of all data bytes
//  ST_DONE  | program verified, CPU released; sync byte starts a reload
//  ST_ERROR | frame rejected, CPU held; sync byte starts a new frame
import imem_loader_pkg::*;

module imem_loader #(
    parameter int         DEPTH     = IMEM_DEPTH,
    parameter int         ADDR_W    = $clog2(DEPTH),
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    imem_loader_if.slave    bus,
    output logic            cpu_hold_o,
    output logic            load_done_o,
    output logic            load_err_o,
    output logic [ADDR_W:0] words_loaded_o
);

    localparam logic [ADDR_W:0]   ONE_W = 1;
    localparam logic [ADDR_W-1:0] ONE_A = 1;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        byte_idx_q;
    logic [7:0]        csum_q;
    logic [23:0]       buf_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   words_q;
    logic              hold_q;
    logic              done_q;
    logic              err_q;

    logic              rx_fire;
    logic              wr_en;
    logic [XLEN-1:0]   wr_data;

    // There is no backpressure: every valid byte is taken.
    assign bus.rx_ready = 1'b1;
    assign rx_fire      = bus.rx_valid;

    // The fourth byte of a word goes straight to the RAM on the edge it arrives.
    assign wr_en   = rx_fire && (state_q == ST_DATA) && (byte_idx_q == 2'd3);
    assign wr_data = merge_word(buf_q, bus.rx_data);

    imem_loader_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .W      (XLEN)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_en),
        .waddr_i (addr_q),
        .wdata_i (wr_data),
        .raddr_i (bus.rd_addr),
        .rdata_o (bus.rd_data)
    );

    // Frame-parsing FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
            buf_q      <= '0;
            n_q        <= '0;
            words_q    <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (rx_fire) begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    // Status is sticky until a new frame actually begins.
                    if (bus.rx_data == SYNC_BYTE) begin
                        state_q    <= ST_COUNT;
                        hold_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        words_q    <= '0;
                        addr_q     <= '0;
                        byte_idx_q <= '0;
                        csum_q     <= '0;
                    end
                end
                ST_COUNT: begin
                    if (bus.rx_data == 8'd0 || bus.rx_data > 8'(DEPTH)) begin
                        state_q <= ST_ERROR;
                        err_q   <= 1'b1;
                    end else begin
                        n_q     <= bus.rx_data[ADDR_W:0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    csum_q <= csum_q ^ bus.rx_data;
                    case (byte_idx_q)
                        2'd0: buf_q[7:0]   <= bus.rx_data;
                        2'd1: buf_q[15:8]  <= bus.rx_data;
                        2'd2: buf_q[23:16] <= bus.rx_data;
                        default: ;
                    endcase
                    if (byte_idx_q == 2'd3) begin
                        byte_idx_q <= '0;
                        addr_q     <= addr_q + ONE_A;
                        words_q    <= words_q + ONE_W;
                        if ((words_q + ONE_W) == n_q) begin
                            state_q <= ST_CHECK;
                        end
                    end else begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                    end
                end
                ST_CHECK: begin
                    if (bus.rx_data == csum_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                    end else begin
                        state_q <= ST_ERROR;
                        err_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    hold_q  <= 1'b1;
                end
            endcase
        end
    end

    assign cpu_hold_o     = hold_q;
    assign load_done_o    = done_q;
    assign load_err_o     = err_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected status/read
// results, a negedge monitor pops and compares them.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;
    logic [4:0] words_loaded;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(4)) bus ();

    imem_loader dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .cpu_hold_o     (cpu_hold),
        .load_done_o    (load_done),
        .load_err_o     (load_err),
        .words_loaded_o (words_loaded)
    );

    typedef struct {
        bit          is_rd;
        int          due;
        logic [31:0] data;
        logic        hold;
        logic        done;
        logic        err;
        logic [4:0]  words;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;
    logic [7:0]  fr[$];

    exp_t        e;
    string       nm;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h", n, act, expv);
    endtask

    // Monitor: compare every expectation that has come due.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.is_rd) begin
                chk({nm, ".rd_data"}, bus.rd_data, e.data);
            end else begin
                chk({nm, ".cpu_hold"},     32'(cpu_hold),     32'(e.hold));
                chk({nm, ".load_done"},    32'(load_done),    32'(e.done));
                chk({nm, ".load_err"},     32'(load_err),     32'(e.err));
                chk({nm, ".words_loaded"}, 32'(words_loaded), 32'(e.words));
                chk({nm, ".rx_ready"},     32'(bus.rx_ready), 32'd1);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Idle bus carries a sync byte so that ignoring rx_valid=0 is exercised.
    task automatic send_byte(input logic [7:0] b, input int gap);
        idle(gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'hA5;
    endtask

    task automatic send_fr(input int gap_max);
        foreach (fr[i]) send_byte(fr[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    endtask

    task automatic exp_status(input string n, input logic h, input logic d,
                              input logic er, input logic [4:0] w);
        exp_t x;
        x.is_rd = 1'b0; x.due = cyc; x.data = '0;
        x.hold = h; x.done = d; x.err = er; x.words = w;
        exp_q.push_back(x);
        name_q.push_back(n);
    endtask

    task automatic push_rd(input string n, input int due, input logic [31:0] d);
        exp_t x;
        x.is_rd = 1'b1; x.due = due; x.data = d;
        x.hold = 1'b0; x.done = 1'b0; x.err = 1'b0; x.words = '0;
        exp_q.push_back(x);
        name_q.push_back(n);
    endtask

    task automatic exp_read(input string n, input logic [3:0] a, input logic [31:0] d);
        bus.rd_addr = a;
        push_rd(n, cyc + 1, d);
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame1(input int gap_max);
        fr = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00, 8'hE1};
        send_fr(gap_max);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] cs;
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'hA5;
        bus.rd_addr  = '0;
        idle(3);
        exp_status("reset", 1'b1, 1'b0, 1'b0, 5'd0);
        exp_read("reset_rd", 4'd0, 32'h0);
        rst = 1'b0;
        idle(2);

        // Plain frame.
        load_frame1(0);
        exp_status("s1", 1'b0, 1'b1, 1'b0, 5'd2);
        exp_read("s1_w0", 4'd0, 32'h00500093);
        exp_read("s1_w1", 4'd1, 32'h00300113);

        // Bad checksum, then recovery.
        fr = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00, 8'hE0};
        send_fr(0);
        exp_status("s2_bad", 1'b1, 1'b0, 1'b1, 5'd2);
        load_frame1(0);
        exp_status("s2_ok", 1'b0, 1'b1, 1'b0, 5'd2);

        // Illegal word counts.
        fr = '{8'hA5, 8'h00};
        send_fr(0);
        exp_status("s3_n0", 1'b1, 1'b0, 1'b1, 5'd0);
        fr = '{8'hA5, 8'h11};
        send_fr(0);
        exp_status("s3_n17", 1'b1, 1'b0, 1'b1, 5'd0);
        send_byte(8'h93, 0);
        exp_status("s3_ignore", 1'b1, 1'b0, 1'b1, 5'd0);

        // Garbage before sync, random gaps.
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        fr = '{8'h00, 8'hFF, 8'h5A};
        send_fr(3);
        exp_status("s4_garbage", 1'b1, 1'b0, 1'b0, 5'd0);
        load_frame1(3);
        exp_status("s4", 1'b0, 1'b1, 1'b0, 5'd2);
        exp_read("s4_w0", 4'd0, 32'h00500093);
        exp_read("s4_w1", 4'd1, 32'h00300113);

        // Reset mid-frame.
        fr = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01};
        send_fr(0);
        exp_status("s5_mid", 1'b1, 1'b0, 1'b0, 5'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_status("s5_rst", 1'b1, 1'b0, 1'b0, 5'd0);
        exp_read("s5_keep", 4'd0, 32'h00500093);
        load_frame1(0);
        exp_status("s5_ok", 1'b0, 1'b1, 1'b0, 5'd2);

        // Fetch while released, then reload request.
        exp_read("s6_rd", 4'd1, 32'h00300113);
        send_byte(8'h12, 0);
        exp_status("s6_ignore", 1'b0, 1'b1, 1'b0, 5'd2);
        send_byte(8'hA5, 0);
        exp_status("s6_reload", 1'b1, 1'b0, 1'b0, 5'd0);

        // Reload one word; read of the word being written returns old data.
        fr = '{8'h01, 8'hEF, 8'hBE, 8'hAD};
        send_fr(0);
        bus.rd_addr = 4'd0;
        push_rd("s7_rbw", cyc + 1, 32'h00500093);
        send_byte(8'hDE, 0);
        send_byte(8'h22, 0);
        exp_status("s7", 1'b0, 1'b1, 1'b0, 5'd1);
        exp_read("s7_new", 4'd0, 32'hDEADBEEF);
        exp_read("s7_w1", 4'd1, 32'h00300113);

        // Full-depth frame.
        fr = '{8'hA5, 8'h10};
        cs = 8'h00;
        for (int k = 0; k < 16; k++) begin
            fr.push_back(8'(k)); fr.push_back(8'h33); fr.push_back(8'h22); fr.push_back(8'h11);
            cs = cs ^ 8'(k) ^ 8'h33 ^ 8'h22 ^ 8'h11;
        end
        fr.push_back(cs);
        send_fr(1);
        exp_status("s8", 1'b0, 1'b1, 1'b0, 5'd16);
        exp_read("s8_w0", 4'd0, 32'h11223300);
        exp_read("s8_w15", 4'd15, 32'h1122330F);

        idle(3);
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
